// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-ported RAM between the fetch and load/store
// ports: per-access arbitration, 1-cycle read latency, acks and stall request.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_ack_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [3:0]        data_sel_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_ack_o,
  output logic              stallreq_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    I_WAIT,
    D_WAIT
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_d;
  logic   last_d_nxt;
  logic   d_we_q;
  logic   req_i;
  logic   req_d;
  logic   gnt_i;
  logic   gnt_d;

  always_comb begin
    inst_ack_o  = (state == I_WAIT) && !rst;
    data_ack_o  = (state == D_WAIT) && !rst;
    // The port being acked this cycle cannot be granted again yet
    req_i       = inst_ce_i && !inst_ack_o && !rst;
    req_d       = data_ce_i && !data_ack_o && !rst;
    gnt_i       = 1'b0;
    gnt_d       = 1'b0;
    if (req_i && req_d) begin
      gnt_d = (FIXED_PRIO != 0) || !last_d;
      gnt_i = !gnt_d;
    end else begin
      gnt_i = req_i;
      gnt_d = req_d;
    end
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_sel_o   = 4'b0000;
    mem_wdata_o = '0;
    state_nxt   = IDLE;
    last_d_nxt  = last_d;
    unique case (1'b1)
      gnt_d: begin
        mem_ce_o    = 1'b1;
        mem_we_o    = data_we_i;
        mem_addr_o  = data_addr_i;
        mem_sel_o   = data_sel_i;
        mem_wdata_o = data_wdata_i;
        state_nxt   = D_WAIT;
        last_d_nxt  = 1'b1;
      end
      gnt_i: begin
        mem_ce_o    = 1'b1;
        mem_addr_o  = inst_addr_i;
        mem_sel_o   = 4'b1111;
        state_nxt   = I_WAIT;
        last_d_nxt  = 1'b0;
      end
      default: begin
      end
    endcase
    inst_o     = inst_ack_o ? mem_rdata_i : '0;
    data_o     = (data_ack_o && !d_we_q) ? mem_rdata_i : '0;
    stallreq_o = (inst_ce_i && !inst_ack_o) ||
                 (data_ce_i && !data_ack_o);
  end

  // Reset leaves last_d set so the first tie goes to the fetch port
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
      d_we_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      if (gnt_d) d_we_q <= data_we_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle table plus ack scoreboard on a
// round-robin instance, hand sequence on a fixed-priority instance.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        inst_ce = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_o;
  logic        inst_ack;
  logic        data_ce = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_sel = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_o;
  logic        data_ack;
  logic        stallreq;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        f_rst = 1'b1;
  logic        f_ice = 1'b0;
  logic [31:0] f_iaddr = '0;
  logic [31:0] f_inst_o;
  logic        f_iack;
  logic        f_dce = 1'b0;
  logic [31:0] f_daddr = '0;
  logic [31:0] f_data_o;
  logic        f_dack;
  logic        f_stall;
  logic        f_mce;
  logic        f_mwe;
  logic [31:0] f_maddr;
  logic [3:0]  f_msel;
  logic [31:0] f_mwdata;
  logic [31:0] f_rdata = 32'hA5A5_0000;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr),
    .inst_o(inst_o), .inst_ack_o(inst_ack),
    .data_ce_i(data_ce), .data_we_i(data_we),
    .data_addr_i(data_addr), .data_sel_i(data_sel),
    .data_wdata_i(data_wdata), .data_o(data_o),
    .data_ack_o(data_ack), .stallreq_o(stallreq),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_sel_o(mem_sel),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_f (
    .clk(clk), .rst(f_rst),
    .inst_ce_i(f_ice), .inst_addr_i(f_iaddr),
    .inst_o(f_inst_o), .inst_ack_o(f_iack),
    .data_ce_i(f_dce), .data_we_i(1'b0),
    .data_addr_i(f_daddr), .data_sel_i(4'b1111),
    .data_wdata_i(32'h0), .data_o(f_data_o),
    .data_ack_o(f_dack), .stallreq_o(f_stall),
    .mem_ce_o(f_mce), .mem_we_o(f_mwe),
    .mem_addr_o(f_maddr), .mem_sel_o(f_msel),
    .mem_wdata_o(f_mwdata), .mem_rdata_i(f_rdata)
  );

  logic [31:0] ram  [256];
  logic [31:0] gold [256];

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_sel[b])
            ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always @(negedge clk) begin
    if (inst_ack) begin
      if (iq.size() == 0) chk("inst_ack_unexpected", 32'd1, 32'd0);
      else chk("inst_o", inst_o, iq.pop_front());
    end else if (inst_o !== 32'h0) begin
      chk("inst_o_noack", inst_o, 32'h0);
    end
    if (data_ack) begin
      if (dq.size() == 0) chk("data_ack_unexpected", 32'd1, 32'd0);
      else chk("data_o", data_o, dq.pop_front());
    end else if (data_o !== 32'h0) begin
      chk("data_o_noack", data_o, 32'h0);
    end
  end

  // exp = {mem_ce, mem_we, inst_ack, data_ack, stallreq}
  typedef struct packed {
    logic        r;
    logic        ice;
    logic [31:0] ia;
    logic        inew;
    logic        dce;
    logic        dwe;
    logic [31:0] da;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic        dnew;
    logic [4:0]  exp;
    logic [31:0] ea;
  } vec_t;

  function automatic vec_t v(
    input logic r, input logic ice, input logic [31:0] ia,
    input logic inew, input logic dce, input logic dwe,
    input logic [31:0] da, input logic [3:0] sel,
    input logic [31:0] wd, input logic dnew,
    input logic [4:0] exp, input logic [31:0] ea);
    v = '{r, ice, ia, inew, dce, dwe, da, sel, wd, dnew, exp, ea};
  endfunction

  vec_t tbl[30];

  initial begin
    logic [31:0] f_exp_addr [6];
    logic [1:0]  f_exp_ack  [6];
    for (int i = 0; i < 256; i++) begin
      ram[i]  = 32'h1000_0000 | (i * 4);
      gold[i] = 32'h1000_0000 | (i * 4);
    end
    ram[64]  = 32'h3C01_0101;
    gold[64] = 32'h3C01_0101;

    tbl[0]  = v(1, 1, 'h100, 1, 1, 0, 'h40, 4'hF, 0, 1, 5'b00001, 0);
    tbl[1]  = v(1, 1, 'h100, 0, 1, 0, 'h40, 4'hF, 0, 0, 5'b00001, 0);
    tbl[2]  = v(0, 1, 'h100, 0, 1, 0, 'h40, 4'hF, 0, 0, 5'b10001, 'h100);
    tbl[3]  = v(0, 1, 'h100, 0, 1, 0, 'h40, 4'hF, 0, 0, 5'b10101, 'h40);
    tbl[4]  = v(0, 0, 0, 0, 1, 0, 'h40, 4'hF, 0, 0, 5'b00010, 0);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 5'b00000, 0);
    tbl[6]  = v(0, 1, 'h100, 1, 0, 0, 0, 4'h0, 0, 0, 5'b10001, 'h100);
    tbl[7]  = v(0, 1, 'h100, 0, 0, 0, 0, 4'h0, 0, 0, 5'b00100, 0);
    tbl[8]  = v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 5'b00000, 0);
    tbl[9]  = v(0, 0, 0, 0, 1, 1, 'h20, 4'hF, 'hDEADBEEF, 1, 5'b11001, 'h20);
    tbl[10] = v(0, 0, 0, 0, 1, 1, 'h20, 4'hF, 'hDEADBEEF, 0, 5'b00010, 0);
    tbl[11] = v(0, 0, 0, 0, 1, 0, 'h20, 4'hF, 0, 1, 5'b10001, 'h20);
    tbl[12] = v(0, 0, 0, 0, 1, 0, 'h20, 4'hF, 0, 0, 5'b00010, 0);
    tbl[13] = v(0, 0, 0, 0, 1, 1, 'h20, 4'b0001, 'h55, 1, 5'b11001, 'h20);
    tbl[14] = v(0, 0, 0, 0, 1, 1, 'h20, 4'b0001, 'h55, 0, 5'b00010, 0);
    tbl[15] = v(0, 0, 0, 0, 1, 0, 'h20, 4'hF, 0, 1, 5'b10001, 'h20);
    tbl[16] = v(0, 0, 0, 0, 1, 0, 'h20, 4'hF, 0, 0, 5'b00010, 0);
    tbl[17] = v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 5'b00000, 0);
    tbl[18] = v(0, 1, 'h104, 1, 1, 0, 'h24, 4'hF, 0, 1, 5'b10001, 'h104);
    tbl[19] = v(0, 1, 'h104, 0, 1, 0, 'h24, 4'hF, 0, 0, 5'b10101, 'h24);
    tbl[20] = v(0, 1, 'h108, 1, 1, 0, 'h24, 4'hF, 0, 0, 5'b10011, 'h108);
    tbl[21] = v(0, 1, 'h108, 0, 1, 0, 'h28, 4'hF, 0, 1, 5'b10101, 'h28);
    tbl[22] = v(0, 1, 'h10C, 1, 1, 0, 'h28, 4'hF, 0, 0, 5'b10011, 'h10C);
    tbl[23] = v(0, 1, 'h10C, 0, 0, 0, 0, 4'h0, 0, 0, 5'b00100, 0);
    tbl[24] = v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 5'b00000, 0);
    tbl[25] = v(0, 0, 0, 0, 1, 0, 'h30, 4'hF, 0, 1, 5'b10001, 'h30);
    tbl[26] = v(1, 0, 0, 0, 1, 0, 'h30, 4'hF, 0, 0, 5'b00001, 0);
    tbl[27] = v(0, 0, 0, 0, 1, 0, 'h30, 4'hF, 0, 0, 5'b10001, 'h30);
    tbl[28] = v(0, 0, 0, 0, 1, 0, 'h30, 4'hF, 0, 0, 5'b00010, 0);
    tbl[29] = v(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 5'b00000, 0);

    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      rst        = tbl[i].r;
      inst_ce    = tbl[i].ice;
      inst_addr  = tbl[i].ia;
      data_ce    = tbl[i].dce;
      data_we    = tbl[i].dwe;
      data_addr  = tbl[i].da;
      data_sel   = tbl[i].sel;
      data_wdata = tbl[i].wd;
      if (tbl[i].inew) iq.push_back(gold[tbl[i].ia[9:2]]);
      if (tbl[i].dnew) begin
        if (tbl[i].dwe) begin
          for (int b = 0; b < 4; b++)
            if (tbl[i].sel[b])
              gold[tbl[i].da[9:2]][b*8 +: 8] = tbl[i].wd[b*8 +: 8];
          dq.push_back(32'h0);
        end else begin
          dq.push_back(gold[tbl[i].da[9:2]]);
        end
      end
      @(negedge clk);
      chk($sformatf("ctrl[%0d]", i),
          {27'h0, mem_ce, mem_we, inst_ack, data_ack, stallreq},
          {27'h0, tbl[i].exp});
      chk($sformatf("addr[%0d]", i), mem_addr, tbl[i].ea);
    end
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    // Fixed priority: data wins ties, fetch slips into each data WAIT cycle
    f_exp_addr = '{'h80, 'h200, 'h80, 'h200, 'h80, 'h0};
    f_exp_ack  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      f_rst   = 1'b0;
      f_dce   = 1'b1;
      f_ice   = (c >= 1) && (c <= 4);
      f_iaddr = 32'h200;
      f_daddr = 32'h80;
      @(negedge clk);
      chk($sformatf("fix_addr[%0d]", c), f_maddr, f_exp_addr[c]);
      chk($sformatf("fix_ack[%0d]", c), {30'h0, f_iack, f_dack},
          {30'h0, f_exp_ack[c]});
      if (f_iack) chk($sformatf("fix_inst[%0d]", c), f_inst_o, 32'hA5A5_0000);
    end
    @(posedge clk);
    #1;
    f_dce = 1'b0;
    f_ice = 1'b0;
    @(negedge clk);
    chk("fix_idle", {31'h0, f_mce}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
